mem_best_neighbor_scan: RTL and testbench

- Bus initiator for the 2048x8 byte-addressed node memory, which presents a 16-bit big-endian word per access, has a combinational read and a synchronous write.
- On `start`, it reads `neighborCount` and walks the `qValue` table to find the neighbor with the largest Q-value.
- It fetches that neighbor's ID, then writes the ID and Q-value back to a result slot in memory.
- It sits between the routing control FSM and the memory, and is the active end of the memory's address/wr_en/data port.

---
 rtl/mem_best_neighbor_scan_if.sv | 24 ++
 rtl/mem_best_neighbor_scan.sv | 161 ++++++++++++++++
 tb/tb_mem_best_neighbor_scan.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_best_neighbor_scan_if.sv
// Memory port between the best-neighbor scanner (master) and the 2048x8 node memory (slave).
interface mem_best_neighbor_scan_if #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 16
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_wr_en;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_address,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_address,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_best_neighbor_scan.sv
// Walks the qValue table for the neighbor with the largest Q-value,
// fetches its ID and writes ID and Q-value back to the result slot.
module mem_best_neighbor_scan #(
  parameter int                ADDR_W       = 11,
  parameter int                WORD_W       = 16,
  parameter logic [ADDR_W-1:0] NBR_CNT_ADDR = 11'h68A,
  parameter logic [ADDR_W-1:0] QVAL_BASE    = 11'h1C8,
  parameter logic [ADDR_W-1:0] NBRID_BASE   = 11'h048,
  parameter logic [ADDR_W-1:0] RESULT_ADDR  = 11'h70E,
  parameter int                MAX_NBR      = 64
) (
  input  logic                        clock,
  input  logic                        nrst,
  input  logic                        en,
  input  logic                        start,
  mem_best_neighbor_scan_if.master    bus,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W-1:0]           best_id,
  output logic [WORD_W-1:0]           best_q
);

  localparam int IDX_W = $clog2(MAX_NBR + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    RD_Q,
    RD_ID,
    WR_ID,
    WR_Q,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [WORD_W-1:0] best_q_q, best_q_d;
  logic [WORD_W-1:0] best_id_q, best_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_q_d   = best_q_q;
    best_id_d  = best_id_q;
    addr_d     = addr_q;
    wr_en_d    = wr_en_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RD_CNT;
        end
        RD_CNT: begin
          if (bus.mem_rdata > WORD_W'(MAX_NBR)) cnt_d = IDX_W'(MAX_NBR);
          else                                  cnt_d = bus.mem_rdata[IDX_W-1:0];
          idx_d = '0;
          if (cnt_d == '0) begin
            best_q_d   = '0;
            best_idx_d = '0;
            best_id_d  = '0;
            state_d    = WR_ID;
          end else begin
            state_d = RD_Q;
          end
        end
        RD_Q: begin
          // Strict compare so ties keep the earliest index.
          if ((idx_q == '0) || (bus.mem_rdata > best_q_q)) begin
            best_q_d   = bus.mem_rdata;
            best_idx_d = idx_q;
          end
          if (idx_q == cnt_q - IDX_W'(1)) state_d = RD_ID;
          else                            idx_d   = idx_q + IDX_W'(1);
        end
        RD_ID: begin
          best_id_d = bus.mem_rdata;
          state_d   = WR_ID;
        end
        WR_ID:   state_d = WR_Q;
        WR_Q:    state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      // Registered bus/status outputs are decoded from the upcoming state so the
      // address is already on the bus during the cycle that consumes mem_rdata.
      addr_d  = '0;
      wr_en_d = 1'b0;
      wdata_d = '0;
      done_d  = 1'b0;
      busy_d  = (state_d != IDLE);
      case (state_d)
        RD_CNT: addr_d = NBR_CNT_ADDR;
        RD_Q:   addr_d = QVAL_BASE + ADDR_W'({idx_d, 1'b0});
        RD_ID:  addr_d = NBRID_BASE + ADDR_W'({best_idx_d, 1'b0});
        WR_ID: begin
          addr_d  = RESULT_ADDR;
          wr_en_d = 1'b1;
          wdata_d = best_id_d;
        end
        WR_Q: begin
          addr_d  = RESULT_ADDR + ADDR_W'(2);
          wr_en_d = 1'b1;
          wdata_d = best_q_d;
        end
        DONE:    done_d = 1'b1;
        default: addr_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q_q   <= '0;
      best_id_q  <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_q_q   <= best_q_d;
      best_id_q  <= best_id_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A frozen block must never write or signal completion, even mid-cycle.
  assign bus.mem_address = addr_q;
  assign bus.mem_wr_en   = wr_en_q & en;
  assign bus.mem_wdata   = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q & en;
  assign best_id         = best_id_q;
  assign best_q          = best_q_q;

endmodule

// File: tb/tb_mem_best_neighbor_scan.sv
// Self-checking bench: byte-wide memory model plus a table-level reference of
// the best-neighbor search, with directed cases and randomized scans.
module tb_mem_best_neighbor_scan;

  localparam logic [10:0] NBR_CNT_ADDR = 11'h68A;
  localparam logic [10:0] QVAL_BASE    = 11'h1C8;
  localparam logic [10:0] NBRID_BASE   = 11'h048;
  localparam logic [10:0] RESULT_ADDR  = 11'h70E;

  logic        clock = 1'b0;
  logic        nrst;
  logic        en;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] best_id;
  logic [15:0] best_q;

  int checks = 0;
  int errors = 0;
  int wr_en_low_hits = 0;

  logic [7:0]  mem [0:2047];
  logic [10:0] addr_log [$];
  logic [10:0] exp_addr [$];

  mem_best_neighbor_scan_if bus_if ();

  mem_best_neighbor_scan dut (
    .clock   (clock),
    .nrst    (nrst),
    .en      (en),
    .start   (start),
    .bus     (bus_if),
    .busy    (busy),
    .done    (done),
    .best_id (best_id),
    .best_q  (best_q)
  );

  always #5 clock = ~clock;

  // Big-endian combinational read of the byte memory.
  logic [10:0] rd_addr_hi;
  logic [10:0] rd_addr_lo;
  assign rd_addr_hi = bus_if.mem_address;
  assign rd_addr_lo = bus_if.mem_address + 11'd1;
  assign bus_if.mem_rdata = {mem[rd_addr_hi], mem[rd_addr_lo]};

  // Synchronous write, plus a watch for writes while the block is disabled.
  always @(posedge clock) begin
    if (bus_if.mem_wr_en) begin
      mem[rd_addr_hi] = bus_if.mem_wdata[15:8];
      mem[rd_addr_lo] = bus_if.mem_wdata[7:0];
    end
    if (!en && bus_if.mem_wr_en) wr_en_low_hits++;
  end

  // Record every read address the scanner presents on an enabled edge.
  always @(posedge clock) begin
    if (nrst && en && busy && !done && !bus_if.mem_wr_en)
      addr_log.push_back(bus_if.mem_address);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] getWord(input logic [10:0] a);
    logic [10:0] a1;
    a1 = a + 11'd1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic setWord(input logic [10:0] a, input logic [15:0] v);
    logic [10:0] a1;
    a1 = a + 11'd1;
    mem[a]  = v[15:8];
    mem[a1] = v[7:0];
  endtask

  // Reference: find the maximum Q, then the first index that holds it.
  task automatic refModel(output int n, output logic [15:0] e_id, output logic [15:0] e_q,
                          output int e_cycles);
    logic [15:0] raw;
    logic [15:0] q;
    int          first;
    raw = getWord(NBR_CNT_ADDR);
    n = (raw > 16'd64) ? 64 : int'(raw);
    e_q = 16'h0000;
    for (int i = 0; i < n; i++) begin
      q = getWord(QVAL_BASE + 11'(2 * i));
      if (q > e_q) e_q = q;
    end
    first = 0;
    for (int i = n - 1; i >= 0; i--)
      if (getWord(QVAL_BASE + 11'(2 * i)) == e_q) first = i;
    e_id = (n > 0) ? getWord(NBRID_BASE + 11'(2 * first)) : 16'h0000;
    e_cycles = (n > 0) ? n + 5 : 4;
    exp_addr.delete();
    exp_addr.push_back(NBR_CNT_ADDR);
    for (int i = 0; i < n; i++) exp_addr.push_back(QVAL_BASE + 11'(2 * i));
    if (n > 0) exp_addr.push_back(NBRID_BASE + 11'(2 * first));
  endtask

  // Launch a scan from just after an edge and count edges until done shows up.
  task automatic applyStimulus(input int drop_at, input int drop_len, input int restart_at,
                               input int reset_at, output int cycles, output bit got_done);
    addr_log.delete();
    start    = 1'b1;
    cycles   = 0;
    got_done = 1'b0;
    while (cycles < 300) begin
      @(posedge clock);
      cycles++;
      #1;
      start = (restart_at != 0) && (cycles == restart_at);
      if (drop_at != 0 && cycles == drop_at) en = 1'b0;
      if (drop_at != 0 && cycles == drop_at + drop_len) en = 1'b1;
      if (reset_at != 0 && cycles == reset_at) begin
        checkOutput("pre_reset_wr_en", bus_if.mem_wr_en, 1'b1);
        nrst = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_en", bus_if.mem_wr_en, 1'b0);
        checkOutput("rst_address", bus_if.mem_address, 11'h000);
        checkOutput("rst_wdata", bus_if.mem_wdata, 16'h0000);
        checkOutput("rst_best_id", best_id, 16'h0000);
        checkOutput("rst_best_q", best_q, 16'h0000);
        #1;
        nrst = 1'b1;
        start = 1'b0;
        return;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    en    = 1'b1;
  endtask

  task automatic runScan(input string tag, input int drop_at, input int drop_len, input int restart_at);
    int          n;
    int          e_cycles;
    int          cycles;
    bit          got_done;
    logic [15:0] e_id;
    logic [15:0] e_q;
    refModel(n, e_id, e_q, e_cycles);
    applyStimulus(drop_at, drop_len, restart_at, 0, cycles, got_done);
    checkOutput($sformatf("%s_done_seen", tag), got_done, 1'b1);
    checkOutput($sformatf("%s_cycles", tag), cycles, e_cycles + ((drop_at != 0) ? drop_len : 0));
    checkOutput($sformatf("%s_best_id", tag), best_id, e_id);
    checkOutput($sformatf("%s_best_q", tag), best_q, e_q);
    checkOutput($sformatf("%s_mem_id", tag), getWord(RESULT_ADDR), e_id);
    checkOutput($sformatf("%s_mem_q", tag), getWord(RESULT_ADDR + 11'd2), e_q);
    checkOutput($sformatf("%s_addr_count", tag), addr_log.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < addr_log.size(); k++)
      checkOutput($sformatf("%s_addr%0d", tag, k), addr_log[k], exp_addr[k]);
    @(posedge clock);
    #1;
    checkOutput($sformatf("%s_idle_busy", tag), busy, 1'b0);
    checkOutput($sformatf("%s_idle_done", tag), done, 1'b0);
    checkOutput($sformatf("%s_hold_id", tag), best_id, e_id);
  endtask

  task automatic loadTables(input logic [15:0] cnt, input logic [15:0] qv [], input logic [15:0] ids []);
    setWord(NBR_CNT_ADDR, cnt);
    foreach (qv[i])  setWord(QVAL_BASE + 11'(2 * i), qv[i]);
    foreach (ids[i]) setWord(NBRID_BASE + 11'(2 * i), ids[i]);
  endtask

  // Directed cases from the block's test plan, then randomized scans.
  initial begin
    int          cycles;
    bit          got_done;
    int          n;
    int          e_cycles;
    int          drop_at;
    int          drop_len;
    int          restart_at;
    int          mode;
    logic [15:0] e_id;
    logic [15:0] e_q;

    for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
    nrst  = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    #2;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_address", bus_if.mem_address, 11'h000);
    checkOutput("reset_wr_en", bus_if.mem_wr_en, 1'b0);
    checkOutput("reset_wdata", bus_if.mem_wdata, 16'h0000);
    checkOutput("reset_best_id", best_id, 16'h0000);
    checkOutput("reset_best_q", best_q, 16'h0000);
    repeat (2) @(posedge clock);
    #3;
    nrst = 1'b1;
    @(posedge clock);
    #1;

    loadTables(16'd4, '{16'h0780, 16'h0500, 16'h0460, 16'h0140}, '{16'd1, 16'd3, 16'd4, 16'd6});
    runScan("descending", 0, 0, 0);
    checkOutput("desc_bytes", {mem[11'h70E], mem[11'h70F], mem[11'h710], mem[11'h711]}, 32'h0001_0780);

    loadTables(16'd4, '{16'h0140, 16'h0460, 16'h0500, 16'h0780}, '{16'd1, 16'd3, 16'd4, 16'd6});
    runScan("ascending", 0, 0, 0);

    loadTables(16'd0, '{16'h1234}, '{16'h5678});
    runScan("zero_count", 0, 0, 0);

    loadTables(16'd3, '{16'h0500, 16'h0500, 16'h0100}, '{16'd7, 16'd8, 16'd9});
    runScan("tie", 0, 0, 0);

    setWord(NBR_CNT_ADDR, 16'd100);
    runScan("clamp_100", 0, 0, 0);

    setWord(NBR_CNT_ADDR, 16'h0100);
    runScan("clamp_256", 0, 0, 0);

    loadTables(16'd4, '{16'h0140, 16'h0460, 16'h0500, 16'h0780}, '{16'd1, 16'd3, 16'd4, 16'd6});
    runScan("en_drop", 2, 3, 0);
    runScan("restart_busy", 0, 0, 4);

    loadTables(16'd4, '{16'h0780, 16'h0500, 16'h0460, 16'h0140}, '{16'd1, 16'd3, 16'd4, 16'd6});
    setWord(RESULT_ADDR, 16'hDEAD);
    setWord(RESULT_ADDR + 11'd2, 16'hBEEF);
    applyStimulus(0, 0, 0, 7, cycles, got_done);
    checkOutput("reset_abort_done", got_done, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_abort_busy", busy, 1'b0);
    checkOutput("reset_abort_mem_id", getWord(RESULT_ADDR), 16'hDEAD);
    checkOutput("reset_abort_mem_q", getWord(RESULT_ADDR + 11'd2), 16'hBEEF);

    for (int t = 0; t < 16; t++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0)      setWord(NBR_CNT_ADDR, 16'd0);
      else if (mode == 1) setWord(NBR_CNT_ADDR, 16'($urandom_range(65, 65535)));
      else                setWord(NBR_CNT_ADDR, 16'($urandom_range(1, 64)));
      for (int i = 0; i < 64; i++) begin
        setWord(QVAL_BASE + 11'(2 * i), (t % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom));
        setWord(NBRID_BASE + 11'(2 * i), 16'($urandom));
      end
      refModel(n, e_id, e_q, e_cycles);
      drop_at    = 0;
      drop_len   = 0;
      restart_at = 0;
      if ($urandom_range(0, 1) == 1) begin
        drop_at  = $urandom_range(2, e_cycles - 1);
        drop_len = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 1) == 1) restart_at = $urandom_range(2, e_cycles - 1);
      runScan($sformatf("rand%0d", t), drop_at, drop_len, restart_at);
    end

    checkOutput("wr_en_while_disabled", wr_en_low_hits, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
